dpll_phase_detector: RTL and testbench
======================================

# dpll_phase_detector

Bang-bang phase/frequency comparator at the front of the DPLL. Compares rising edges of the external reference `master_in` against the locally recovered clock `slave_in`, which is the loop filter's `slave_out` fed back. Per edge pair it produces the `lead`/`lag` decision and a phase-error magnitude. It drives the `lead` input of `Digital_Loop_Filter`, closing the loop.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `master_in`; the matching delay depth on `slave_in`.
- `CW`, 8: width of the cycle counter and of `err_mag`.
- `WINDOW`, 255: maximum cycles to wait for a partner edge. Must satisfy 1 ≤ WINDOW ≤ 2^CW−1.
- `DEADBAND`, 1: error magnitude treated as in-phase. Used only with `DEADBAND_EN`.

- `clk`  in  1: single clock, rising-edge.
- `rstn`  in  1: reset, synchronous, active-low.
- `master_in`  in  1: asynchronous reference signal.
- `slave_in`  in  1: recovered clock, synchronous to `clk`.
- `lead`  out  1: registered level. 1 = slave edge came before master edge on the last decision.
- `lag`  out  1: registered level. 1 = master edge came before slave edge on the last decision.
- `pd_valid`  out  1: one-cycle pulse marking a new decision.
- `err_mag`  out  CW: cycles between the edges of the last decision. Held between decisions.
- `miss`  out  1: one-cycle pulse when a partner edge did not arrive within `WINDOW` cycles.

## Operation
- `master_in` passes through a `SYNC_STAGES`-flop synchronizer. `slave_in` passes through an equal-depth delay line so both paths have identical latency.
- Rising-edge detect on each path: pulse = cur & ~prev. The prev flops reset to 1, so an input already high at reset gives no edge.
- FSM states:
  - `IDLE`
    - master edge only → `WAIT_S`, cnt=1.
    - slave edge only → `WAIT_M`, cnt=1.
    - both edges in the same cycle → decision with err=0 (lead=0, lag=0).
  - `WAIT_S`
    - slave edge → decision lag=1, err=cnt, → `IDLE`.
    - else master edge → restart: cnt=1, stay.
    - else cnt==WINDOW → `miss`, → `IDLE`.
    - else cnt+1.
  - `WAIT_M`: mirror of `WAIT_S` with roles swapped; decision lead=1.
- Partner edge has priority over a same-side edge in the same cycle. The same-side edge is dropped and not re-armed.
- A partner edge arriving in the same cycle that cnt==WINDOW is still a valid decision with err=WINDOW. No `miss` is raised.
- On a decision:
  - `pd_valid`=1 for one cycle.
  - `lead`, `lag` and `err_mag` update in the same cycle and hold until the next decision.
  - `lead` and `lag` are never both 1.
- `miss` leaves `lead`, `lag` and `err_mag` unchanged.
- cnt never exceeds WINDOW. No wrap is possible.

## Timing
- Reset (rstn=0 at a clk edge):
  - state=`IDLE`, cnt=0.
  - `lead`, `lag`, `pd_valid` and `miss` = 0; `err_mag`=0.
  - Synchronizer and delay flops = 0; edge prev flops = 1.
- Reset asserted mid-measurement aborts it. No `pd_valid` or `miss` is emitted.
- Pin to edge pulse: SYNC_STAGES+1 cycles on both paths.
- Second edge pulse to `pd_valid`/`lead`/`lag`/`err_mag`: 1 cycle (registered).
- err_mag = (cycle of second edge pulse) − (cycle of first edge pulse).
- `miss` asserts exactly WINDOW+1 cycles after the first edge pulse.
- Back-to-back decisions are possible: after returning to `IDLE`, a new edge is accepted in the very next cycle.

## Configuration
- `DPLL_PD_DEADBAND_EN`
  - Defined: a decision with err_mag ≤ DEADBAND still pulses `pd_valid` and loads `err_mag`, but forces lead=0 and lag=0.
  - Undefined: the `DEADBAND` parameter is ignored. Any nonzero error sets `lead` or `lag`; only err=0 gives lead=lag=0.

## Test plan
- Reset: hold rstn=0 with master_in=1 and slave_in=1 for 4 cycles, then release → all outputs 0, no `pd_valid` and no `miss` within 10 cycles.
- Master edge 5 cycles before slave edge → one `pd_valid` pulse, lag=1, lead=0, err_mag=5.
- Slave edge 3 cycles before master edge → `pd_valid`, lead=1, lag=0, err_mag=3. Outputs then hold over 20 idle cycles.
- Edges in the same cycle → `pd_valid`, lead=0, lag=0, err_mag=0.
- WINDOW=16, master edge with no slave edge → `miss` pulse 17 cycles after the master edge pulse; lead/lag/err_mag unchanged. A second master edge at cnt=4 restarts the count instead: `miss` comes 17 cycles after the second edge.
- With `DPLL_PD_DEADBAND_EN` and DEADBAND=1:
  - Slave edge 1 cycle early → `pd_valid`, lead=0, lag=0, err_mag=1.
  - Slave edge 2 cycles early → lead=1, err_mag=2.

Source files
------------

// File: rtl/dpll_phase_detector.sv
`default_nettype none
// ============================================================================
//  Module      : dpll_phase_detector
//  Description : Bang-bang phase/frequency comparator for the DPLL front end.
//                Compares rising edges of the asynchronous reference
//                master_in against the recovered clock slave_in. For each
//                edge pair it emits a lead/lag decision plus the phase-error
//                magnitude in clk cycles. It raises miss when no partner
//                edge arrives within WINDOW cycles.
//  Options     : DPLL_PD_DEADBAND_EN - when defined, decisions with
//                err_mag <= DEADBAND report lead = lag = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpll_phase_detector #(
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 8,
    parameter int WINDOW      = 255,
    parameter int DEADBAND    = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          master_in,
    input  logic          slave_in,
    output logic          lead,
    output logic          lag,
    output logic          pd_valid,
    output logic [CW-1:0] err_mag,
    output logic          miss
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_S = 2'd1,
        WAIT_M = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_window = CW'(WINDOW);
    localparam logic [CW-1:0] c_one    = CW'(1);

    // Synchronizer on master_in, equal-depth delay line on slave_in.
    logic [SYNC_STAGES-1:0] m_sync_q, m_sync_d;
    logic [SYNC_STAGES-1:0] s_dly_q,  s_dly_d;
    // Tracks when the reset zeros have been flushed out of both lines.
    logic [SYNC_STAGES-1:0] fill_q,   fill_d;

    logic m_prev_q, m_prev_d;
    logic s_prev_q, s_prev_d;
    logic m_edge_q, m_edge_d;
    logic s_edge_q, s_edge_d;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          lead_q,     lead_d;
    logic          lag_q,      lag_d;
    logic          pd_valid_q, pd_valid_d;
    logic          miss_q,     miss_d;
    logic [CW-1:0] err_q,      err_d;

    logic w_m_cur;
    logic w_s_cur;
    logic w_fill_done;

    assign w_m_cur     = m_sync_q[SYNC_STAGES-1];
    assign w_s_cur     = s_dly_q[SYNC_STAGES-1];
    assign w_fill_done = fill_q[SYNC_STAGES-1];

    generate
        if (SYNC_STAGES > 1) begin : g_line_multi
            // Shift the new samples in at bit 0; the oldest sample sits at the top.
            always_comb begin
                m_sync_d = {m_sync_q[SYNC_STAGES-2:0], master_in};
                s_dly_d  = {s_dly_q[SYNC_STAGES-2:0],  slave_in};
                fill_d   = {fill_q[SYNC_STAGES-2:0],   1'b1};
            end
        end else begin : g_line_single
            // Single-stage line: each register simply samples its input.
            always_comb begin
                m_sync_d = master_in;
                s_dly_d  = slave_in;
                fill_d   = 1'b1;
            end
        end
    endgenerate

    // Rising-edge detect. The reset zeros coming out of the lines are not real
    // input levels, so prev is held at 1 until the lines hold real samples.
    // An input that is already high across reset therefore gives no edge.
    always_comb begin
        m_prev_d = w_fill_done ? w_m_cur : 1'b1;
        s_prev_d = w_fill_done ? w_s_cur : 1'b1;
        m_edge_d = w_m_cur & ~m_prev_q;
        s_edge_d = w_s_cur & ~s_prev_q;
    end

`ifndef DPLL_PD_DEADBAND_EN
    // Keeps the parameter referenced when the deadband is compiled out.
    logic w_unused_deadband;
    assign w_unused_deadband = ^DEADBAND;
`endif

    // Measurement FSM: next state, cycle counter and registered decision outputs.
    always_comb begin
        logic          dec;
        logic          dec_lead;
        logic          dec_lag;
        logic          in_band;
        logic [CW-1:0] dec_err;

        state_d    = state_q;
        cnt_d      = cnt_q;
        lead_d     = lead_q;
        lag_d      = lag_q;
        err_d      = err_q;
        pd_valid_d = 1'b0;
        miss_d     = 1'b0;
        dec        = 1'b0;
        dec_lead   = 1'b0;
        dec_lag    = 1'b0;
        dec_err    = '0;
        in_band    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_edge_q && s_edge_q) begin
                    dec = 1'b1;
                end else if (m_edge_q) begin
                    state_d = WAIT_S;
                    cnt_d   = c_one;
                end else if (s_edge_q) begin
                    state_d = WAIT_M;
                    cnt_d   = c_one;
                end
            end
            WAIT_S: begin
                // A partner edge wins over a same-side edge in the same cycle.
                if (s_edge_q) begin
                    dec     = 1'b1;
                    dec_lag = 1'b1;
                    dec_err = cnt_q;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (m_edge_q) begin
                    cnt_d = c_one;
                end else if (cnt_q == c_window) begin
                    miss_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            WAIT_M: begin
                if (m_edge_q) begin
                    dec      = 1'b1;
                    dec_lead = 1'b1;
                    dec_err  = cnt_q;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (s_edge_q) begin
                    cnt_d = c_one;
                end else if (cnt_q == c_window) begin
                    miss_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef DPLL_PD_DEADBAND_EN
        in_band = (dec_err <= CW'(DEADBAND));
`endif

        if (dec) begin
            pd_valid_d = 1'b1;
            err_d      = dec_err;
            lead_d     = dec_lead & ~in_band;
            lag_d      = dec_lag  & ~in_band;
        end
    end

    // All state registers share one synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_sync_q   <= '0;
            s_dly_q    <= '0;
            fill_q     <= '0;
            m_prev_q   <= 1'b1;
            s_prev_q   <= 1'b1;
            m_edge_q   <= 1'b0;
            s_edge_q   <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            lead_q     <= 1'b0;
            lag_q      <= 1'b0;
            pd_valid_q <= 1'b0;
            miss_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            m_sync_q   <= m_sync_d;
            s_dly_q    <= s_dly_d;
            fill_q     <= fill_d;
            m_prev_q   <= m_prev_d;
            s_prev_q   <= s_prev_d;
            m_edge_q   <= m_edge_d;
            s_edge_q   <= s_edge_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lead_q     <= lead_d;
            lag_q      <= lag_d;
            pd_valid_q <= pd_valid_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
        end
    end

    assign lead     = lead_q;
    assign lag      = lag_q;
    assign pd_valid = pd_valid_q;
    assign miss     = miss_q;
    assign err_mag  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dpll_phase_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpll_phase_detector
//  Description : Directed self-checking bench for dpll_phase_detector
//                (WINDOW = 16, SYNC_STAGES = 2, DEADBAND = 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpll_phase_detector;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          master_in;
    logic          slave_in;
    logic          lead;
    logic          lag;
    logic          pd_valid;
    logic [CW-1:0] err_mag;
    logic          miss;

    int n_assert = 0;
    int n_fail   = 0;

    dpll_phase_detector #(
        .SYNC_STAGES (2),
        .CW          (CW),
        .WINDOW      (16),
        .DEADBAND    (1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .master_in (master_in),
        .slave_in  (slave_in),
        .lead      (lead),
        .lag       (lag),
        .pd_valid  (pd_valid),
        .err_mag   (err_mag),
        .miss      (miss)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks until pd_valid, bounded; also notes any miss seen on the way.
    task automatic wait_pd(output int n, output logic saw_miss);
        n = 0;
        saw_miss = 1'b0;
        do begin
            tick();
            n++;
            if (miss === 1'b1) saw_miss = 1'b1;
        end while (pd_valid !== 1'b1 && n < 60);
    endtask

    // Ticks until miss, bounded; also notes any pd_valid seen on the way.
    task automatic wait_miss(output int n, output logic saw_pd);
        n = 0;
        saw_pd = 1'b0;
        do begin
            tick();
            n++;
            if (pd_valid === 1'b1) saw_pd = 1'b1;
        end while (miss !== 1'b1 && n < 60);
    endtask

    task automatic drop_inputs();
        master_in = 1'b0;
        slave_in  = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int   n;
        logic flag;

        // Reset with both inputs high.
        rstn      = 1'b0;
        master_in = 1'b1;
        slave_in  = 1'b1;
        repeat (4) tick();
        check("rst_lead",     lead,     0);
        check("rst_lag",      lag,      0);
        check("rst_pd_valid", pd_valid, 0);
        check("rst_miss",     miss,     0);
        check("rst_err_mag",  err_mag,  0);
        rstn = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (pd_valid !== 1'b0 || miss !== 1'b0 || lead !== 1'b0 ||
                lag !== 1'b0 || err_mag !== 8'd0) flag = 1'b1;
        end
        check("quiet_after_reset", flag, 0);
        drop_inputs();

        // Master edge 5 cycles before slave edge.
        master_in = 1'b1;
        repeat (5) tick();
        slave_in = 1'b1;
        wait_pd(n, flag);
        check("lag5_latency", n,       4);
        check("lag5_lag",     lag,     1);
        check("lag5_lead",    lead,    0);
        check("lag5_err",     err_mag, 5);
        tick();
        check("lag5_pulse_width", pd_valid, 0);
        drop_inputs();

        // Slave edge 3 cycles before master edge, then hold.
        slave_in = 1'b1;
        repeat (3) tick();
        master_in = 1'b1;
        wait_pd(n, flag);
        check("lead3_latency", n,       4);
        check("lead3_lead",    lead,    1);
        check("lead3_lag",     lag,     0);
        check("lead3_err",     err_mag, 3);
        master_in = 1'b0;
        slave_in  = 1'b0;
        repeat (20) begin
            tick();
            check("lead3_hold", {pd_valid, miss, lead, lag, err_mag}, {1'b0, 1'b0, 1'b1, 1'b0, 8'd3});
        end

        // Master edge with no partner: miss 17 cycles after the edge pulse.
        master_in = 1'b1;
        wait_miss(n, flag);
        check("miss_latency", n,       20);
        check("miss_no_pd",   flag,    0);
        check("miss_lead",    lead,    1);
        check("miss_lag",     lag,     0);
        check("miss_err",     err_mag, 3);
        tick();
        check("miss_pulse_width", miss, 0);
        drop_inputs();

        // Second master edge at cnt=4 restarts the count.
        master_in = 1'b1;
        repeat (2) tick();
        master_in = 1'b0;
        repeat (2) tick();
        master_in = 1'b1;
        wait_miss(n, flag);
        check("restart_latency", n,    20);
        check("restart_no_pd",   flag, 0);
        drop_inputs();

        // Partner edge exactly at cnt == WINDOW: decision, no miss.
        master_in = 1'b1;
        repeat (16) tick();
        slave_in = 1'b1;
        wait_pd(n, flag);
        check("win_latency", n,       4);
        check("win_no_miss", flag,    0);
        check("win_lag",     lag,     1);
        check("win_lead",    lead,    0);
        check("win_err",     err_mag, 16);
        tick();
        check("win_miss_after", miss, 0);
        drop_inputs();

        // Both edges in the same cycle.
        master_in = 1'b1;
        slave_in  = 1'b1;
        wait_pd(n, flag);
        check("same_latency", n,       4);
        check("same_lead",    lead,    0);
        check("same_lag",     lag,     0);
        check("same_err",     err_mag, 0);
        drop_inputs();

        // Slave edge 1 cycle early: inside the deadband when it is enabled.
        slave_in = 1'b1;
        tick();
        master_in = 1'b1;
        wait_pd(n, flag);
        check("db1_latency", n,       4);
        check("db1_err",     err_mag, 1);
        check("db1_lag",     lag,     0);
`ifdef DPLL_PD_DEADBAND_EN
        check("db1_lead",    lead,    0);
`else
        check("db1_lead",    lead,    1);
`endif
        drop_inputs();

        // Slave edge 2 cycles early: outside the deadband.
        slave_in = 1'b1;
        repeat (2) tick();
        master_in = 1'b1;
        wait_pd(n, flag);
        check("db2_latency", n,       4);
        check("db2_err",     err_mag, 2);
        check("db2_lead",    lead,    1);
        check("db2_lag",     lag,     0);
        drop_inputs();

        // Reset in the middle of a measurement aborts it silently.
        master_in = 1'b1;
        repeat (6) tick();
        rstn = 1'b0;
        tick();
        check("midrst_lead", lead,    0);
        check("midrst_err",  err_mag, 0);
        rstn = 1'b1;
        flag = 1'b0;
        repeat (25) begin
            tick();
            if (pd_valid !== 1'b0 || miss !== 1'b0) flag = 1'b1;
        end
        check("midrst_quiet", flag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
